boot_sequencer: RTL and testbench

Parametrised power-up and reset sequencer for the FPGA wrappers: sits between the clock generator(s) and the `riscv_soc` instance(s). It waits for all clock-lock inputs to be stable, holds the SoC in reset, releases several reset domains in staggered order and only then raises `fetch_enable`. It re-runs the sequence on lock loss or on an external reset request. It replaces the direct `fetch_enable = locked` tie with a counted, glitch-tolerant sequence that supports several domains.

---
 rtl/boot_sequencer.sv | 160 ++++++++++++++++
 tb/tb_boot_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/boot_sequencer.sv
// Power-up/reset sequencer: waits for stable clock lock, holds reset, releases domains
// in staggered order, then raises fetch enable. Define BOOT_SEQ_LOCK_SYNC_EN to synchronise locked_i.
module boot_sequencer #(
    parameter int NUM_LOCK           = 1,
    parameter int NUM_RST            = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RST_HOLD_CYCLES    = 256,
    parameter int STAGGER_CYCLES     = 16,
    parameter int FETCH_DELAY_CYCLES = 32
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic [NUM_LOCK-1:0] locked_i,
    input  logic                ext_rst_req_i,
    output logic [NUM_RST-1:0]  rst_n_o,
    output logic                fetch_enable_o,
    output logic                all_locked_o,
    output logic [2:0]          state_o,
    output logic [7:0]          relock_cnt_o
);

    localparam int MAX_A   = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
    localparam int MAX_B   = (STAGGER_CYCLES > FETCH_DELAY_CYCLES) ? STAGGER_CYCLES : FETCH_DELAY_CYCLES;
    localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int IDX_W   = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

    localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] FETCH_LAST   = CNT_W'(FETCH_DELAY_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_RST - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK  = 3'd0,
        HOLD       = 3'd1,
        RELEASE    = 3'd2,
        FETCH_WAIT = 3'd3,
        RUN        = 3'd4
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic [NUM_RST-1:0] rst_n_q;
    logic               fetch_q;
    logic [7:0]         relock_q;
    logic [NUM_LOCK-1:0] lock_vec;
    logic               lock_ok;

`ifdef BOOT_SEQ_LOCK_SYNC_EN
    logic [NUM_LOCK-1:0] lock_meta_q;
    logic [NUM_LOCK-1:0] lock_sync_q;

    // locked_i comes from other clock domains; two flops per bit resolve metastability.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            lock_meta_q <= '0;
            lock_sync_q <= '0;
        end else begin
            lock_meta_q <= locked_i;
            lock_sync_q <= lock_meta_q;
        end
    end

    assign lock_vec = lock_sync_q;
`else
    assign lock_vec = locked_i;
`endif

    assign lock_ok = &lock_vec;

    // NOTE: all state is updated with non-blocking assignments so every branch sees
    // the pre-edge values of state_q/cnt_q/idx_q, regardless of statement order.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q  <= WAIT_LOCK;
            cnt_q    <= '0;
            idx_q    <= '0;
            rst_n_q  <= '0;
            fetch_q  <= 1'b0;
            relock_q <= '0;
        end else if (!lock_ok && state_q != WAIT_LOCK) begin
            // Lock loss outranks an external request on the same cycle.
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_n_q <= '0;
            fetch_q <= 1'b0;
            if (relock_q != 8'hFF) relock_q <= relock_q + 8'd1;
        end else if (ext_rst_req_i &&
                     (state_q == RELEASE || state_q == FETCH_WAIT || state_q == RUN)) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_n_q <= '0;
            fetch_q <= 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (!lock_ok) begin
                        cnt_q <= '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_q <= HOLD;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    rst_n_q <= '0;
                    if (ext_rst_req_i) begin
                        cnt_q <= '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_q <= RELEASE;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (cnt_q == STAGGER_LAST) begin
                        rst_n_q[idx_q] <= 1'b1;
                        cnt_q          <= '0;
                        if (idx_q == IDX_LAST) state_q <= FETCH_WAIT;
                        else                   idx_q   <= idx_q + IDX_W'(1);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                FETCH_WAIT: begin
                    if (cnt_q == FETCH_LAST) begin
                        state_q <= RUN;
                        fetch_q <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    fetch_q <= 1'b1;
                end
                default: begin
                    state_q <= WAIT_LOCK;
                    cnt_q   <= '0;
                    rst_n_q <= '0;
                    fetch_q <= 1'b0;
                end
            endcase
        end
    end

    assign rst_n_o        = rst_n_q;
    assign fetch_enable_o = fetch_q;
    assign all_locked_o   = lock_ok;
    assign state_o        = state_q;
    assign relock_cnt_o   = relock_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed testbench for boot_sequencer with short timing parameters.
module tb_boot_sequencer;

`ifdef BOOT_SEQ_LOCK_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    logic       clk_sys = 1'b0;
    logic       reset;
    logic [1:0] locked_i;
    logic       ext_rst_req_i;
    logic [2:0] rst_n_o;
    logic       fetch_enable_o;
    logic       all_locked_o;
    logic [2:0] state_o;
    logic [7:0] relock_cnt_o;

    int n_pass  = 0;
    int n_total = 0;

    boot_sequencer #(
        .NUM_LOCK(2), .NUM_RST(3), .LOCK_STABLE_CYCLES(4),
        .RST_HOLD_CYCLES(8), .STAGGER_CYCLES(2), .FETCH_DELAY_CYCLES(3)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .locked_i      (locked_i),
        .ext_rst_req_i (ext_rst_req_i),
        .rst_n_o       (rst_n_o),
        .fetch_enable_o(fetch_enable_o),
        .all_locked_o  (all_locked_o),
        .state_o       (state_o),
        .relock_cnt_o  (relock_cnt_o)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Leaves reset deasserted with both locks high; the next posedge is edge 1.
    task automatic do_reset();
        reset = 1'b1; locked_i = 2'b00; ext_rst_req_i = 1'b0;
        tick();
        reset = 1'b0; locked_i = 2'b11;
    endtask

    task automatic test_reset();
        reset = 1'b1; locked_i = 2'b00; ext_rst_req_i = 1'b0;
        tick(); tick();
        n_total++; if (state_o !== 3'd0) $display("FAIL reset_state got=%0d exp=0", state_o); else n_pass++;
        n_total++; if (rst_n_o !== 3'b000) $display("FAIL reset_rst_n got=%b exp=000", rst_n_o); else n_pass++;
        n_total++; if (fetch_enable_o !== 1'b0) $display("FAIL reset_fetch got=%b exp=0", fetch_enable_o); else n_pass++;
        n_total++; if (relock_cnt_o !== 8'd0) $display("FAIL reset_relock got=%0d exp=0", relock_cnt_o); else n_pass++;
        n_total++; if (all_locked_o !== 1'b0) $display("FAIL reset_all_locked got=%b exp=0", all_locked_o); else n_pass++;
    endtask

    task automatic test_clean_boot();
        do_reset();
        for (int e = 1; e <= 21 + L; e++) begin
            tick();
            if (e == 3 + L) begin
                n_total++; if (state_o !== 3'd0) $display("FAIL boot_wait_e3 got=%0d exp=0", state_o); else n_pass++;
                n_total++; if (all_locked_o !== 1'b1) $display("FAIL boot_all_locked got=%b exp=1", all_locked_o); else n_pass++;
            end
            if (e == 4 + L) begin
                n_total++; if (state_o !== 3'd1) $display("FAIL boot_hold_e4 got=%0d exp=1", state_o); else n_pass++;
            end
            if (e == 12 + L) begin
                n_total++; if (state_o !== 3'd2) $display("FAIL boot_release_e12 got=%0d exp=2", state_o); else n_pass++;
            end
            if (e == 13 + L) begin
                n_total++; if (rst_n_o !== 3'b000) $display("FAIL boot_rst_e13 got=%b exp=000", rst_n_o); else n_pass++;
            end
            if (e == 14 + L) begin
                n_total++; if (rst_n_o !== 3'b001) $display("FAIL boot_rst_e14 got=%b exp=001", rst_n_o); else n_pass++;
            end
            if (e == 16 + L) begin
                n_total++; if (rst_n_o !== 3'b011) $display("FAIL boot_rst_e16 got=%b exp=011", rst_n_o); else n_pass++;
            end
            if (e == 18 + L) begin
                n_total++; if (rst_n_o !== 3'b111) $display("FAIL boot_rst_e18 got=%b exp=111", rst_n_o); else n_pass++;
                n_total++; if (state_o !== 3'd3) $display("FAIL boot_fetchwait_e18 got=%0d exp=3", state_o); else n_pass++;
            end
            if (e == 20 + L) begin
                n_total++; if (fetch_enable_o !== 1'b0) $display("FAIL boot_fetch_e20 got=%b exp=0", fetch_enable_o); else n_pass++;
            end
        end
        n_total++; if (fetch_enable_o !== 1'b1) $display("FAIL boot_fetch_e21 got=%b exp=1", fetch_enable_o); else n_pass++;
        n_total++; if (state_o !== 3'd4) $display("FAIL boot_run_e21 got=%0d exp=4", state_o); else n_pass++;
        n_total++; if (relock_cnt_o !== 8'd0) $display("FAIL boot_relock got=%0d exp=0", relock_cnt_o); else n_pass++;
    endtask

    task automatic test_lock_glitch();
        do_reset();
        ticks(2);
        locked_i[1] = 1'b0;
        tick();
        locked_i[1] = 1'b1;
        ticks(3 + L);
        n_total++; if (state_o !== 3'd0) $display("FAIL glitch_e6 got=%0d exp=0", state_o); else n_pass++;
        tick();
        n_total++; if (state_o !== 3'd1) $display("FAIL glitch_e7 got=%0d exp=1", state_o); else n_pass++;
        n_total++; if (relock_cnt_o !== 8'd0) $display("FAIL glitch_relock got=%0d exp=0", relock_cnt_o); else n_pass++;
    endtask

    task automatic test_lock_loss_run();
        do_reset();
        ticks(21 + L);
        locked_i[0] = 1'b0;
        ticks(1 + L);
        n_total++; if (rst_n_o !== 3'b000) $display("FAIL loss_rst got=%b exp=000", rst_n_o); else n_pass++;
        n_total++; if (fetch_enable_o !== 1'b0) $display("FAIL loss_fetch got=%b exp=0", fetch_enable_o); else n_pass++;
        n_total++; if (state_o !== 3'd0) $display("FAIL loss_state got=%0d exp=0", state_o); else n_pass++;
        n_total++; if (relock_cnt_o !== 8'd1) $display("FAIL loss_relock got=%0d exp=1", relock_cnt_o); else n_pass++;
        locked_i[0] = 1'b1;
        ticks(20 + L);
        n_total++; if (fetch_enable_o !== 1'b0) $display("FAIL relock_fetch_e20 got=%b exp=0", fetch_enable_o); else n_pass++;
        tick();
        n_total++; if (fetch_enable_o !== 1'b1) $display("FAIL relock_fetch_e21 got=%b exp=1", fetch_enable_o); else n_pass++;
        n_total++; if (rst_n_o !== 3'b111) $display("FAIL relock_rst got=%b exp=111", rst_n_o); else n_pass++;
    endtask

    task automatic test_ext_req_release();
        do_reset();
        ticks(14 + L);
        n_total++; if (rst_n_o !== 3'b001) $display("FAIL ext_pre_rst got=%b exp=001", rst_n_o); else n_pass++;
        ext_rst_req_i = 1'b1;
        tick();
        ext_rst_req_i = 1'b0;
        n_total++; if (rst_n_o !== 3'b000) $display("FAIL ext_rst got=%b exp=000", rst_n_o); else n_pass++;
        n_total++; if (state_o !== 3'd1) $display("FAIL ext_state got=%0d exp=1", state_o); else n_pass++;
        ticks(7);
        n_total++; if (state_o !== 3'd1) $display("FAIL ext_hold_7 got=%0d exp=1", state_o); else n_pass++;
        tick();
        n_total++; if (state_o !== 3'd2) $display("FAIL ext_release_8 got=%0d exp=2", state_o); else n_pass++;
        ticks(2);
        n_total++; if (rst_n_o !== 3'b001) $display("FAIL ext_resume_rst got=%b exp=001", rst_n_o); else n_pass++;
        n_total++; if (relock_cnt_o !== 8'd0) $display("FAIL ext_relock got=%0d exp=0", relock_cnt_o); else n_pass++;
    endtask

    task automatic test_simultaneous_and_saturation();
        do_reset();
        ticks(21 + L);
        locked_i = 2'b01; ext_rst_req_i = 1'b1;
        ticks(1 + L);
        ext_rst_req_i = 1'b0;
        n_total++; if (state_o !== 3'd0) $display("FAIL simul_state got=%0d exp=0", state_o); else n_pass++;
        n_total++; if (relock_cnt_o !== 8'd1) $display("FAIL simul_relock got=%0d exp=1", relock_cnt_o); else n_pass++;
        for (int i = 0; i < 253; i++) begin
            locked_i = 2'b11; ticks(4 + L);
            locked_i = 2'b00; ticks(1 + L);
        end
        n_total++; if (relock_cnt_o !== 8'd254) $display("FAIL sat_254 got=%0d exp=254", relock_cnt_o); else n_pass++;
        for (int i = 0; i < 46; i++) begin
            locked_i = 2'b11; ticks(4 + L);
            locked_i = 2'b00; ticks(1 + L);
        end
        n_total++; if (relock_cnt_o !== 8'd255) $display("FAIL sat_255 got=%0d exp=255", relock_cnt_o); else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        ticks(19 + L);
        n_total++; if (state_o !== 3'd3) $display("FAIL async_pre_state got=%0d exp=3", state_o); else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_total++; if (state_o !== 3'd0) $display("FAIL async_state got=%0d exp=0", state_o); else n_pass++;
        n_total++; if (rst_n_o !== 3'b000) $display("FAIL async_rst got=%b exp=000", rst_n_o); else n_pass++;
        n_total++; if (fetch_enable_o !== 1'b0) $display("FAIL async_fetch got=%b exp=0", fetch_enable_o); else n_pass++;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; locked_i = 2'b00; ext_rst_req_i = 1'b0;
        test_reset();
        test_clean_boot();
        test_lock_glitch();
        test_lock_loss_run();
        test_ext_req_release();
        test_simultaneous_and_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
